// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU through an IDLE/EXEC/RESP FSM.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req0_op,
   input  logic [2:0]       req1_op,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero,
   output logic [WIDTH-1:0] alu_in_0,
   output logic [WIDTH-1:0] alu_in_1,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_result;
   logic [2:0]       r_op;
   logic             r_id, r_last_grant, r_zero;
   logic             w_idle, w_grant1, w_accept;

   // readies are gated by rst_n so every output reads 0 while reset is held
   assign w_idle = (r_state == IDLE) && rst_n;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
   assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
`else
   assign w_grant1 = req1_valid && !req0_valid;
`endif
   assign w_accept    = w_idle && (req0_valid || req1_valid);
   assign req0_ready  = w_accept && !w_grant1;
   assign req1_ready  = w_accept && w_grant1;
   assign resp_id     = resp_valid && r_id;
   assign resp_result = r_result;
   assign resp_zero   = r_zero;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   // next state and state-decoded outputs
   always_comb begin
      w_next     = r_state;
      busy       = 1'b0;
      resp_valid = 1'b0;
      alu_in_0   = '0;
      alu_in_1   = '0;
      alu_op     = '0;
      case (r_state)
         IDLE: w_next = w_accept ? EXEC : IDLE;
         EXEC: begin
            w_next   = RESP;
            busy     = 1'b1;
            alu_in_0 = r_a;
            alu_in_1 = r_b;
            alu_op   = r_op;
         end
         RESP: begin
            w_next     = resp_ready ? IDLE : RESP;
            busy       = 1'b1;
            resp_valid = 1'b1;
         end
         default: w_next = IDLE;
      endcase
   end

   // operand latch at acceptance, result capture at the end of EXEC
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         r_result     <= '0;
         r_zero       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a          <= w_grant1 ? req1_a : req0_a;
            r_b          <= w_grant1 ? req1_b : req0_b;
            r_op         <= w_grant1 ? req1_op : req0_op;
            r_id         <= w_grant1;
            r_last_grant <= w_grant1;
         end
         if (r_state == EXEC) begin
            r_result <= alu_result;
            r_zero   <= alu_zero;
         end
      end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
   localparam int W = 32;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
   logic [W-1:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic req0_ready, req1_ready, resp_valid, resp_id, resp_zero, busy, alu_zero;
   logic [W-1:0] resp_result, alu_in_0, alu_in_1, alu_result;
   logic [2:0] alu_op;

   int checks = 0, failures = 0;
   logic [W+1:0] sb[$];
   logic g;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
   logic exp_grant[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
   logic exp_grant[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_zero(resp_zero),
      .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
   );

   always_comb begin
      case (alu_op)
         OP_ADD:  alu_result = alu_in_0 + alu_in_1;
         OP_SUB:  alu_result = alu_in_0 - alu_in_1;
         OP_AND:  alu_result = alu_in_0 & alu_in_1;
         OP_OR:   alu_result = alu_in_0 | alu_in_1;
         OP_XOR:  alu_result = alu_in_0 ^ alu_in_1;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag, output logic id);
      int n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
         step();
         n++;
      end
      check({tag, "_ready_seen"}, 32'(req0_ready || req1_ready), 1);
      check({tag, "_ready_onehot"}, 32'(req0_ready && req1_ready), 0);
      id = req1_ready;
   endtask

   task automatic expect_resp(input string tag);
      logic [W+1:0] e;
      int n = 0;
      while (!resp_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_valid"}, 32'(resp_valid), 1);
      check({tag, "_readies_low"}, 32'({req0_ready, req1_ready}), 0);
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_id"}, 32'(resp_id), 32'(e[W+1]));
         check({tag, "_zero"}, 32'(resp_zero), 32'(e[W]));
         check({tag, "_result"}, resp_result, e[W-1:0]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_resp_valid", 32'(resp_valid), 0);
      check("rst_readies", 32'({req0_ready, req1_ready}), 0);
      check("rst_result", resp_result, 0);
      check("rst_alu_in_0", alu_in_0, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      resp_ready = 1'b1;

      req0_valid = 1'b1; req0_a = 5; req0_b = 3; req0_op = OP_ADD;
      #1;
      check("single_req0_ready", 32'(req0_ready), 1);
      check("single_req1_ready", 32'(req1_ready), 0);
      sb.push_back({1'b0, 1'b0, 32'd8});
      step();
      req0_valid = 1'b0;
      check("exec_busy", 32'(busy), 1);
      check("exec_in_0", alu_in_0, 5);
      check("exec_in_1", alu_in_1, 3);
      check("exec_op", 32'(alu_op), 32'(OP_ADD));
      check("exec_ready", 32'(req0_ready), 0);
      step();
      check("single_latency", 32'(resp_valid), 1);
      expect_resp("single");
      step();
      check("single_done_busy", 32'(busy), 0);
      check("single_done_valid", 32'(resp_valid), 0);

      req1_valid = 1'b1; req1_a = 32'h0000_00FF; req1_b = 32'h0000_00FF; req1_op = OP_XOR;
      sb.push_back({1'b1, 1'b1, 32'd0});
      wait_ready("zero", g);
      check("zero_grant", 32'(g), 1);
      step();
      req1_valid = 1'b0;
      expect_resp("zero");
      step();

      req0_a = 10; req0_b = 4; req0_op = OP_SUB;
      req1_a = 7;  req1_b = 7; req1_op = OP_SUB;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ready("cont", g);
         check($sformatf("cont_grant%0d", i), 32'(g), 32'(exp_grant[i]));
         sb.push_back(g ? {1'b1, 1'b1, 32'd0} : {1'b0, 1'b0, 32'd6});
         step();
         expect_resp($sformatf("cont%0d", i));
         step();
         if (i == 3) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end

      resp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_op = OP_OR;
      sb.push_back({1'b0, 1'b0, 32'd3});
      wait_ready("bp", g);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_valid%0d", i), 32'(resp_valid), 1);
         check($sformatf("bp_result%0d", i), resp_result, 3);
         check($sformatf("bp_readies%0d", i), 32'({req0_ready, req1_ready}), 0);
         check($sformatf("bp_busy%0d", i), 32'(busy), 1);
         step();
      end
      resp_ready = 1'b1;
      #1;
      expect_resp("bp");
      step();
      req1_valid = 1'b0;
      check("bp_done_valid", 32'(resp_valid), 0);
      check("bp_done_busy", 32'(busy), 0);

      req1_valid = 1'b1; req1_a = 9; req1_b = 1; req1_op = OP_ADD;
      wait_ready("rst", g);
      step();
      req1_valid = 1'b0;
      check("rst_exec_busy", 32'(busy), 1);
      check("rst_exec_in_0", alu_in_0, 9);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_valid", 32'(resp_valid), 0);
      check("mid_rst_in_0", alu_in_0, 0);
      check("mid_rst_result", resp_result, 0);
      check("mid_rst_id", 32'(resp_id), 0);
      req0_a = 10; req0_b = 4; req0_op = OP_SUB;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
      check("held_rst_valid", 32'(resp_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_req0_ready", 32'(req0_ready), 1);
      check("post_rst_req1_ready", 32'(req1_ready), 0);
      sb.push_back({1'b0, 1'b0, 32'd6});
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      expect_resp("post_rst");
      step();
      check("sb_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
